// File: rtl/fir_coeff_loader.sv
// Coefficient loader for fir_filter: takes NUM_TAPS bytes plus a mod-256
// checksum over valid/ready and writes them into the filter's tap memory.
//   state   | meaning
//   S_IDLE  | waiting for start, not accepting data
//   S_LOAD  | accepting taps, one filter write per accepted byte
//   S_CHECK | accepting the trailing checksum byte
//   S_DONE  | load finished, done/error held until next start
module fir_coeff_loader #(
    parameter int NUM_TAPS = 71,
    parameter int ADDR_W   = 7,
    parameter int COEFF_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               cfg_valid,
    input  logic [COEFF_W-1:0] cfg_data,
    output logic               cfg_ready,
    output logic               coeff_write,
    output logic [ADDR_W-1:0]  coeff_addr,
    output logic [COEFF_W-1:0] coeff_in,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [ADDR_W-1:0]  taps_loaded
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic              active;
    logic [ADDR_W-1:0] index;
    logic [7:0]        sum;
    logic              in_load;
    logic              do_abort;
    logic              do_start;
    logic              accept;
    logic              last_tap;

    assign in_load   = (state == S_LOAD) || (state == S_CHECK);
    assign do_abort  = abort && in_load;
    assign do_start  = start && !abort;
    // start/abort take priority over a byte offered in the same cycle
    assign accept    = cfg_valid && active && !start && !abort;
    assign last_tap  = (index == ADDR_W'(NUM_TAPS - 1));
    assign cfg_ready = active;
    assign busy      = active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = S_IDLE;
            S_LOAD:  if (accept && last_tap) state_next = S_CHECK;
            S_CHECK: if (accept) state_next = S_DONE;
            S_DONE:  state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
        if (do_abort) begin
            state_next = S_IDLE;
        end else if (do_start) begin
            state_next = S_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active      <= 1'b0;
            coeff_write <= 1'b0;
            coeff_addr  <= '0;
            coeff_in    <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            taps_loaded <= '0;
            index       <= '0;
            sum         <= '0;
        end else begin
            active      <= (state_next == S_LOAD) || (state_next == S_CHECK);
            coeff_write <= 1'b0;
            if (do_abort) begin
                error <= 1'b1;
                done  <= 1'b0;
            end else if (do_start) begin
                index       <= '0;
                sum         <= '0;
                done        <= 1'b0;
                error       <= 1'b0;
                taps_loaded <= '0;
            end else if (accept && state == S_LOAD) begin
                coeff_write <= 1'b1;
                coeff_addr  <= index;
                coeff_in    <= cfg_data;
                sum         <= sum + cfg_data[7:0];
                taps_loaded <= taps_loaded + ADDR_W'(1);
                if (!last_tap) begin
                    index <= index + ADDR_W'(1);
                end
            end else if (accept && state == S_CHECK) begin
                done  <= 1'b1;
                error <= (cfg_data[7:0] != sum);
            end
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: ramp, bad checksum, gapped negative
// load, abort, restart and mid-load reset, with hand-computed expectations.
module tb_fir_coeff_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       cfg_valid;
    logic [7:0] cfg_data;
    logic       cfg_ready;
    logic       coeff_write;
    logic [6:0] coeff_addr;
    logic [7:0] coeff_in;
    logic       busy;
    logic       done;
    logic       error;
    logic [6:0] taps_loaded;

    int checks   = 0;
    int failures = 0;

    fir_coeff_loader #(.NUM_TAPS(71), .ADDR_W(7), .COEFF_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .coeff_write(coeff_write), .coeff_addr(coeff_addr), .coeff_in(coeff_in),
        .busy(busy), .done(done), .error(error), .taps_loaded(taps_loaded)
    );

    always #5 clk = ~clk;

    // Drive at a falling edge, let one rising edge pass, return at the next falling edge.
    task automatic step(input logic v, input logic [7:0] d, input logic s, input logic a);
        cfg_valid = v;
        cfg_data  = d;
        start     = s;
        abort     = a;
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({cfg_ready, coeff_write, coeff_addr, coeff_in, busy, done, error, taps_loaded} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b wr=%b addr=%0d in=%0d busy=%b done=%b err=%b taps=%0d want all 0",
                     cfg_ready, coeff_write, coeff_addr, coeff_in, busy, done, error, taps_loaded);
        end
        step(1'b1, 8'h12, 1'b0, 1'b0);
        checks++;
        if ({cfg_ready, coeff_write} !== 2'b00) begin
            failures++;
            $display("FAIL idle_no_accept got rdy=%b wr=%b want 0 0", cfg_ready, coeff_write);
        end
    endtask

    task automatic test_ramp(input logic [7:0] csum, input logic exp_err);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if ({cfg_ready, busy, done, error, taps_loaded} !== {1'b1, 1'b1, 1'b0, 1'b0, 7'd0}) begin
            failures++;
            $display("FAIL ramp_start got rdy=%b busy=%b done=%b err=%b taps=%0d want 1 1 0 0 0",
                     cfg_ready, busy, done, error, taps_loaded);
        end
        for (int i = 0; i < 71; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            checks++;
            if ({coeff_write, coeff_addr, coeff_in, taps_loaded} !== {1'b1, 7'(i), 8'(i), 7'(i + 1)}) begin
                failures++;
                $display("FAIL ramp_write i=%0d got wr=%b addr=%0d in=%0d taps=%0d want 1 %0d %0d %0d",
                         i, coeff_write, coeff_addr, coeff_in, taps_loaded, i, i, i + 1);
            end
        end
        checks++;
        if ({cfg_ready, busy, done} !== 3'b110) begin
            failures++;
            $display("FAIL ramp_in_check got rdy=%b busy=%b done=%b want 1 1 0", cfg_ready, busy, done);
        end
        step(1'b1, csum, 1'b0, 1'b0);
        checks++;
        if ({coeff_write, cfg_ready, busy, done, error, taps_loaded} !== {1'b0, 1'b0, 1'b0, 1'b1, exp_err, 7'd71}) begin
            failures++;
            $display("FAIL ramp_status got wr=%b rdy=%b busy=%b done=%b err=%b taps=%0d want 0 0 0 1 %b 71",
                     coeff_write, cfg_ready, busy, done, error, taps_loaded, exp_err);
        end
        step(1'b1, 8'h33, 1'b0, 1'b0);
        checks++;
        if ({coeff_write, coeff_addr, done, error} !== {1'b0, 7'd70, 1'b1, exp_err}) begin
            failures++;
            $display("FAIL ramp_after_done got wr=%b addr=%0d done=%b err=%b want 0 70 1 %b",
                     coeff_write, coeff_addr, done, error, exp_err);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if ({done, error, busy} !== {1'b1, exp_err, 1'b0}) begin
            failures++;
            $display("FAIL abort_in_done got done=%b err=%b busy=%b want 1 %b 0", done, error, busy, exp_err);
        end
    endtask

    task automatic test_gaps();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 71; i++) begin
            step(1'b1, 8'hFF, 1'b0, 1'b0);
            checks++;
            if ({coeff_write, coeff_addr, coeff_in} !== {1'b1, 7'(i), 8'hFF}) begin
                failures++;
                $display("FAIL gap_write i=%0d got wr=%b addr=%0d in=%h want 1 %0d ff",
                         i, coeff_write, coeff_addr, coeff_in, i);
            end
            step(1'b0, 8'hAA, 1'b0, 1'b0);
            checks++;
            if ({coeff_write, coeff_addr, coeff_in} !== {1'b0, 7'(i), 8'hFF}) begin
                failures++;
                $display("FAIL gap_idle i=%0d got wr=%b addr=%0d in=%h want 0 %0d ff",
                         i, coeff_write, coeff_addr, coeff_in, i);
            end
        end
        step(1'b1, 8'hB9, 1'b0, 1'b0);
        checks++;
        if ({done, error, taps_loaded, busy} !== {1'b1, 1'b0, 7'd71, 1'b0}) begin
            failures++;
            $display("FAIL gap_status got done=%b err=%b taps=%0d busy=%b want 1 0 71 0",
                     done, error, taps_loaded, busy);
        end
    endtask

    task automatic test_abort();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i <= 30; i++) begin
            step(1'b1, 8'(i + 5), 1'b0, 1'b0);
        end
        checks++;
        if ({coeff_write, coeff_addr, coeff_in} !== {1'b1, 7'd30, 8'd35}) begin
            failures++;
            $display("FAIL abort_tap30 got wr=%b addr=%0d in=%0d want 1 30 35", coeff_write, coeff_addr, coeff_in);
        end
        step(1'b1, 8'h99, 1'b0, 1'b1);
        checks++;
        if ({coeff_write, cfg_ready, busy, done, error, taps_loaded} !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd31}) begin
            failures++;
            $display("FAIL abort_status got wr=%b rdy=%b busy=%b done=%b err=%b taps=%0d want 0 0 0 0 1 31",
                     coeff_write, cfg_ready, busy, done, error, taps_loaded);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'h44, 1'b0, 1'b0);
            checks++;
            if ({coeff_write, cfg_ready, error} !== 3'b001) begin
                failures++;
                $display("FAIL abort_no_write i=%0d got wr=%b rdy=%b err=%b want 0 0 1", i, coeff_write, cfg_ready, error);
            end
        end
    endtask

    task automatic test_restart();
        step(1'b1, 8'h77, 1'b1, 1'b0);
        checks++;
        if ({coeff_write, cfg_ready, error, taps_loaded} !== {1'b0, 1'b1, 1'b0, 7'd0}) begin
            failures++;
            $display("FAIL start_idle_valid got wr=%b rdy=%b err=%b taps=%0d want 0 1 0 0",
                     coeff_write, cfg_ready, error, taps_loaded);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'h40, 1'b0, 1'b0);
        end
        step(1'b1, 8'h55, 1'b1, 1'b0);
        checks++;
        if ({coeff_write, busy, taps_loaded} !== {1'b0, 1'b1, 7'd0}) begin
            failures++;
            $display("FAIL restart_clear got wr=%b busy=%b taps=%0d want 0 1 0", coeff_write, busy, taps_loaded);
        end
        for (int i = 0; i < 71; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            checks++;
            if ({coeff_write, coeff_addr, coeff_in} !== {1'b1, 7'(i), 8'(i)}) begin
                failures++;
                $display("FAIL restart_write i=%0d got wr=%b addr=%0d in=%0d want 1 %0d %0d",
                         i, coeff_write, coeff_addr, coeff_in, i, i);
            end
        end
        step(1'b1, 8'hB5, 1'b0, 1'b0);
        checks++;
        if ({done, error} !== 2'b10) begin
            failures++;
            $display("FAIL restart_status got done=%b err=%b want 1 0", done, error);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b1, 1'b1);
        checks++;
        if ({coeff_write, cfg_ready, busy, done, error} !== 5'b00001) begin
            failures++;
            $display("FAIL start_abort_same got wr=%b rdy=%b busy=%b done=%b err=%b want 0 0 0 0 1",
                     coeff_write, cfg_ready, busy, done, error);
        end
    endtask

    task automatic test_reset_midload();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(i + 1), 1'b0, 1'b0);
        end
        cfg_valid = 1'b1;
        cfg_data  = 8'h66;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cfg_ready, coeff_write, coeff_addr, coeff_in, busy, done, error, taps_loaded} !== 27'd0) begin
            failures++;
            $display("FAIL reset_midload got rdy=%b wr=%b addr=%0d in=%0d busy=%b done=%b err=%b taps=%0d want all 0",
                     cfg_ready, coeff_write, coeff_addr, coeff_in, busy, done, error, taps_loaded);
        end
        @(negedge clk);
        step(1'b1, 8'h66, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h21, 1'b0, 1'b0);
            checks++;
            if ({cfg_ready, coeff_write, taps_loaded} !== 9'd0) begin
                failures++;
                $display("FAIL post_reset_idle i=%0d got rdy=%b wr=%b taps=%0d want 0 0 0",
                         i, cfg_ready, coeff_write, taps_loaded);
            end
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if ({cfg_ready, busy} !== 2'b11) begin
            failures++;
            $display("FAIL post_reset_start got rdy=%b busy=%b want 1 1", cfg_ready, busy);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        #1;
        test_reset_check_and_release();
        test_ramp(8'hB5, 1'b0);
        test_ramp(8'h00, 1'b1);
        test_gaps();
        test_abort();
        test_restart();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic test_reset_check_and_release();
        @(negedge clk);
        test_reset_hold();
        rst_n = 1'b1;
        test_reset();
    endtask

    task automatic test_reset_hold();
        @(negedge clk);
        checks++;
        if ({cfg_ready, coeff_write, busy, done, error, taps_loaded} !== 12'd0) begin
            failures++;
            $display("FAIL reset_hold got rdy=%b wr=%b busy=%b done=%b err=%b taps=%0d want all 0",
                     cfg_ready, coeff_write, busy, done, error, taps_loaded);
        end
    endtask

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
Upstream configuration stage for fir_filter. It accepts a byte stream of tap coefficients over a valid/ready handshake and sequences them into the filter's coefficient memory through the coeff_write/coeff_addr/coeff_in write port. After the last tap it takes one trailing mod-256 checksum byte and reports done/error status to the controller.

Parameters:
NUM_TAPS, 71, number of coefficients per load (addresses 0..NUM_TAPS-1)
ADDR_W, 7, width of coeff_addr and taps_loaded
COEFF_W, 8, coefficient width (signed, two's complement)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse: begin a new load (also restarts a load in progress)
abort  input  1  single-cycle pulse: cancel a load in progress
cfg_valid  input  1  cfg_data is valid
cfg_data  input  COEFF_W  coefficient byte, or the checksum byte
cfg_ready  output  1  loader accepts cfg_data this cycle
coeff_write  output  1  write strobe to fir_filter
coeff_addr  output  ADDR_W  tap address to fir_filter
coeff_in  output  COEFF_W  coefficient value to fir_filter
busy  output  1  high in LOAD or CHECK
done  output  1  load complete; sticky until next start, abort or reset
error  output  1  checksum mismatch or abort; sticky until next start or reset
taps_loaded  output  ADDR_W  number of coefficients written in the current load

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including cfg_ready, coeff_write, coeff_addr, coeff_in, busy, done, error and taps_loaded. Index and running sum are cleared. Reset mid-load stops all writes immediately.
- Handshake: a transfer occurs on a rising clk edge with cfg_valid=1 and cfg_ready=1. cfg_ready is a registered output, equal to 1 exactly when the state is LOAD or CHECK. cfg_data does not need to be held when no transfer occurs.
- States:
  - IDLE: cfg_ready=0. On start, go to LOAD and clear index, sum, done, error and taps_loaded.
  - LOAD: each accepted byte is written to the filter.
    - On the following cycle: coeff_write=1 for exactly one cycle, coeff_addr=index, coeff_in=byte.
    - Index increments, sum = (sum + byte) mod 256, and taps_loaded increments with the write.
    - Accepting the byte at index NUM_TAPS-1 moves the state to CHECK.
  - CHECK: the next accepted byte is the checksum; no filter write occurs.
    - If the byte equals sum[7:0], error stays 0; otherwise error=1.
    - done=1 in either case; go to DONE.
  - DONE: cfg_ready=0, busy=0, done held. On start, clear status and go to LOAD.
- Write latency: exactly 1 cycle from the accepting edge to the coeff_write high cycle. coeff_addr and coeff_in hold their last value while coeff_write=0.
- Back-to-back transfers give consecutive coeff_write cycles. Gaps in cfg_valid give gaps in writes. Addresses are always contiguous 0..NUM_TAPS-1 with no skips or repeats.
- start in LOAD or CHECK: restart from index 0 and discard the partial sum. A byte presented in that same cycle is not accepted.
- abort in LOAD or CHECK: go to IDLE with error=1, done=0. A pending registered write still completes; no further writes follow.
- abort in IDLE or DONE: ignored.
- start and abort in the same cycle: abort wins.
- start in IDLE with cfg_valid=1 in the same cycle: the byte is not accepted.
- The index never exceeds NUM_TAPS-1; there is no address wrap.
- The checksum is an unsigned mod-256 sum of the raw bytes.

Test Plan:
- Ramp load: start, then bytes 0..70 back-to-back, then checksum 0xB5 (2485 mod 256). Expect 71 single write pulses with coeff_addr=coeff_in=0..70, each 1 cycle after acceptance; then done=1, error=0, taps_loaded=71, busy=0.
- Bad checksum: same ramp with checksum 0x00 -> done=1, error=1, and all 71 writes still issued.
- Negative values with gaps: 71 bytes of 0xFF, with cfg_valid high only every other cycle, then checksum 0xB9. Expect writes only on accepted cycles, addresses 0..70 contiguous, coeff_in=-1, error=0.
- Abort: abort after tap 30 is accepted -> the tap-30 write completes, then IDLE, cfg_ready=0, error=1, done=0, and no further writes despite cfg_valid=1.
- Restart: start pulse after 10 taps -> the next accepted byte is written at coeff_addr=0; a full 71 taps plus the correct checksum then gives done=1, error=0.
- Reset mid-load: rst_n low at tap 40 -> all outputs 0 asynchronously. After release, cfg_ready stays 0 until start.
